// File: rtl/mul_share_pkg.sv
// Shared constants for the shared-multiplier arbiter: default operand/product widths,
// requester count, and the round-robin index helper.
package mul_share_pkg;

  localparam int DEF_A_W     = 13;
  localparam int DEF_B_W     = 9;
  localparam int DEF_P_W     = DEF_A_W + DEF_B_W;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 2;
  localparam int CNT_W       = 16;

  // (base + k) mod n for base < n and k <= n, without a divider
  function automatic int rr_index(input int base, input int k, input int n);
    int s;
    s = base + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the shared multiplier.
interface mul_share_arbiter_if
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W,
  parameter int ID_W    = DEF_ID_W
) ();

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_data;
  logic                   busy;
  logic [CNT_W-1:0]       issue_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy, issue_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy, issue_cnt
  );

endinterface

// File: rtl/mul_core_13x9.sv
// Two-stage unsigned-by-signed multiplier: operand register, then product register,
// both advancing only on ce. Tags and valid bits live in the parent.
module mul_core_13x9
  import mul_share_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W,
  parameter int P_W = DEF_P_W
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [A_W-1:0]        a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic [A_W-1:0]        a_reg;
  logic signed [B_W-1:0] b_reg;
  logic signed [P_W-1:0] p_reg;
  logic signed [A_W:0]   a_ext;
  logic signed [P_W-1:0] prod;

  // Zero-extend A so it multiplies as a non-negative signed value
  assign a_ext = {1'b0, a_reg};
  assign prod  = P_W'(a_ext) * P_W'(b_reg);

  always_ff @(posedge clk) begin
    if (ce) begin
      a_reg <= a;
      b_reg <= b;
      p_reg <= prod;
    end
  end

  assign p = p_reg;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NUM_REQ requesters,
// with tag/valid pipeline, backpressure and an accepted-request counter.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic              clk,
  input  logic              reset,
  mul_share_arbiter_if.slave bus
);

  logic [A_W-1:0]   a_arr [NUM_REQ];
  logic [B_W-1:0]   b_arr [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    rr_next;
  logic               ce;
  logic               accept;

  logic               v1_reg;
  logic               v2_reg;
  logic [ID_W-1:0]    id1_reg;
  logic [ID_W-1:0]    id2_reg;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [CNT_W-1:0]   issue_cnt_reg;
  logic signed [P_W-1:0] core_p;

  // A full output stage with no consumer freezes the whole pipe
  assign ce     = !v2_reg || bus.rsp_ready;
  assign accept = grant_vld && ce && !reset;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign a_arr[gi]         = bus.req_a[gi*A_W +: A_W];
    assign b_arr[gi]         = bus.req_b[gi*B_W +: B_W];
    assign bus.req_ready[gi] = grant[gi] && ce && !reset;
  end

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_index(int'(rr_ptr_reg), k, NUM_REQ);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (grant_vld) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign rr_next = ID_W'(rr_index(int'(grant_id), 1, NUM_REQ));

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      id1_reg       <= '0;
      id2_reg       <= '0;
      rr_ptr_reg    <= '0;
      issue_cnt_reg <= '0;
    end else begin
      if (ce) begin
        v1_reg  <= accept;
        id1_reg <= grant_id;
        v2_reg  <= v1_reg;
        id2_reg <= id1_reg;
      end
      if (accept) begin
        rr_ptr_reg    <= rr_next;
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
      end
    end
  end

  mul_core_13x9 #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_core (
    .clk (clk),
    .ce  (ce),
    .a   (a_arr[grant_id]),
    .b   (b_arr[grant_id]),
    .p   (core_p)
  );

  // The product registers carry no reset, so gate them with v2 to read zero when empty
  assign bus.rsp_valid = v2_reg;
  assign bus.rsp_id    = id2_reg;
  assign bus.rsp_data  = v2_reg ? core_p : '0;
  assign bus.busy      = v1_reg || v2_reg;
  assign bus.issue_cnt = issue_cnt_reg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: contention, single op, backpressure,
// fairness, mid-flight reset and counter wrap against hand-computed values.
module tb_mul_share_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_share_arbiter_if bus ();

  mul_share_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [12:0] a, input logic [8:0] b);
    bus.req_a[i*13 +: 13] = a;
    bus.req_b[i*9 +: 9]   = b;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    step();
    reset = 1'b0;
  endtask

  logic [21:0] exp_p [4];

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Products: 3*5, 100*-1, 8191*255, 1000*-200 (22-bit two's complement)
    exp_p[0] = 22'd15;
    exp_p[1] = 22'd4194204;
    exp_p[2] = 22'd2088705;
    exp_p[3] = 22'd3994304;
    set_op(0, 13'd3,    9'd5);
    set_op(1, 13'd100,  9'h1FF);
    set_op(2, 13'd8191, 9'h0FF);
    set_op(3, 13'd1000, 9'h138);

    // Reset with all requesters already valid
    bus.req_valid = 4'b1111;
    step();
    step();
    chk("rst_ready",     32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_cnt",       32'(bus.issue_cnt), 32'd0);
    chk("rst_data",      32'(bus.rsp_data),  32'd0);
    chk("rst_id",        32'(bus.rsp_id),    32'd0);

    // Contention: grants 0,1,2,3,0 and back-to-back responses
    reset = 1'b0;
    for (int t = 0; t < 7; t++) begin
      if (t >= 5) bus.req_valid = '0;
      #1;
      chk("cont_ready", 32'(bus.req_ready), (t < 5) ? (32'd1 << (t % 4)) : 32'd0);
      if (t >= 2) begin
        chk("cont_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("cont_rsp_id",    32'(bus.rsp_id),    32'((t - 2) % 4));
        chk("cont_rsp_data",  32'(bus.rsp_data),  32'(exp_p[(t - 2) % 4]));
      end
      step();
    end
    chk("cont_drained", 32'(bus.rsp_valid), 32'd0);
    chk("cont_cnt",     32'(bus.issue_cnt), 32'd5);

    // Single operation: requester 1, 8191 * -256
    do_reset();
    set_op(1, 13'd8191, 9'h100);
    bus.req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = '0;
    #1;
    chk("single_idle_ready", 32'(bus.req_ready), 32'd0);
    chk("single_s1_valid",   32'(bus.rsp_valid), 32'd0);
    chk("single_busy",       32'(bus.busy),      32'd1);
    step();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_rsp_id",    32'(bus.rsp_id),    32'd1);
    chk("single_rsp_data",  32'(bus.rsp_data),  32'd2097408);
    chk("single_cnt",       32'(bus.issue_cnt), 32'd1);
    step();
    chk("single_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("single_done_busy",  32'(bus.busy),      32'd0);

    // Backpressure: two ops in flight, consumer stalls for 5 cycles (rr_ptr = 2 here)
    set_op(1, 13'd2,  9'd3);
    set_op(2, 13'd10, 9'h1F6);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    chk("bp_ready0", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_ready1", 32'(bus.req_ready), 32'd4);
    step();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_stall_id",    32'(bus.rsp_id),    32'd1);
      chk("bp_stall_data",  32'(bus.rsp_data),  32'd6);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd8);
    chk("bp_rsp0_id",       32'(bus.rsp_id),    32'd1);
    chk("bp_rsp0_data",     32'(bus.rsp_data),  32'd6);
    step();
    bus.req_valid = '0;
    #1;
    chk("bp_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp1_id",    32'(bus.rsp_id),    32'd2);
    chk("bp_rsp1_data",  32'(bus.rsp_data),  32'd4194204);
    step();
    chk("bp_rsp2_id",   32'(bus.rsp_id),   32'd3);
    chk("bp_rsp2_data", 32'(bus.rsp_data), 32'd3994304);
    step();
    chk("bp_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_cnt",        32'(bus.issue_cnt), 32'd4);

    // Fairness: after a grant to 2, rr_ptr=3 so requester 3 beats requester 0
    bus.req_valid = 4'b0100;
    #1;
    chk("fair_ready2", 32'(bus.req_ready), 32'd4);
    step();
    bus.req_valid = 4'b1001;
    #1;
    chk("fair_ready3", 32'(bus.req_ready), 32'd8);
    step();
    bus.req_valid = 4'b0001;
    #1;
    chk("fair_ready0", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    repeat (3) step();
    chk("fair_cnt", 32'(bus.issue_cnt), 32'd7);

    // Reset with v1 = v2 = 1
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    #1;
    chk("mid_busy_before",  32'(bus.busy),      32'd1);
    chk("mid_valid_before", 32'(bus.rsp_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_busy",      32'(bus.busy),      32'd0);
    chk("mid_cnt",       32'(bus.issue_cnt), 32'd0);
    chk("mid_data",      32'(bus.rsp_data),  32'd0);
    reset         = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_no_stale", 32'(bus.rsp_valid), 32'd0);
    end

    // Counter wrap: 65537 accepts leave issue_cnt at 1
    bus.req_valid = 4'b0001;
    #1;
    repeat (65535) step();
    chk("wrap_ffff", 32'(bus.issue_cnt), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(bus.issue_cnt), 32'd0);
    step();
    bus.req_valid = '0;
    #1;
    chk("wrap_one", 32'(bus.issue_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
